// File: rtl/rr_mux_4to1_pkg.sv
// Shared definitions for the 4-channel mux/demux pair: channel count,
// select width, default data width and the select encodings that both
// rr_mux_4to1 and demux_4to1 use to tag each word with its channel.
package rr_mux_4to1_pkg;

    localparam int unsigned N_CH      = 4;
    localparam int unsigned SEL_W     = 2;
    localparam int unsigned WIDTH_DEF = 4;

    typedef enum logic [SEL_W-1:0] {
        SEL_CH0 = 2'b00,
        SEL_CH1 = 2'b01,
        SEL_CH2 = 2'b10,
        SEL_CH3 = 2'b11
    } sel_e;

    // One-hot grant to channel index; an all-zero vector maps to channel 0.
    function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [N_CH-1:0] oh);
        logic [SEL_W-1:0] idx;
        idx = SEL_CH0;
        unique case (oh)
            4'b0010: idx = SEL_CH1;
            4'b0100: idx = SEL_CH2;
            4'b1000: idx = SEL_CH3;
            default: idx = SEL_CH0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/rr_mux_4to1_arbiter.sv
// Round-robin arbiter for four requesters.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   req[3:0]  - request vector
//   advance   - a grant is consumed this cycle; rotate the pointer past it
//   gnt[3:0]  - one-hot combinational grant (all zero when no request)
module rr_arbiter_4
    import rr_mux_4to1_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] req,
    input  logic            advance,
    output logic [N_CH-1:0] gnt
);

    logic [SEL_W-1:0] ptr;

    // Priority search starting at ptr, wrapping modulo 4.
    always_comb begin
        logic             found;
        logic [SEL_W-1:0] idx;
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < int'(N_CH); k++) begin
            idx = ptr + SEL_W'(k);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    // Pointer moves to the channel just after the winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= SEL_CH0;
        end else if (advance) begin
            ptr <= onehot_to_idx(gnt) + SEL_W'(1);
        end
    end

endmodule

// File: rtl/rr_mux_4to1.sv
// Four-channel valid/ready round-robin mux with a registered output
// carrying the source index, so a demux_4to1 can route words back.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   in0..in3          - channel data
//   in_valid[3:0]     - per-channel valid
//   in_ready[3:0]     - per-channel consume strobe (one-hot or zero)
//   out, s, out_valid - registered output word, source index, valid
//   out_ready         - sink accepts the output word
module rr_mux_4to1
    import rr_mux_4to1_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [N_CH-1:0]  in_valid,
    output logic [N_CH-1:0]  in_ready,
    output logic [WIDTH-1:0] out,
    output logic [SEL_W-1:0] s,
    output logic             out_valid,
    input  logic             out_ready
);

    logic             load_c;
    logic             advance_c;
    logic [N_CH-1:0]  gnt_c;
    logic [SEL_W-1:0] gnt_idx_c;
    logic [WIDTH-1:0] gnt_data_c;

    // Output register free, or being drained this same cycle.
    assign load_c    = !out_valid || out_ready;
    assign advance_c = load_c && (|in_valid) && !rst;

    rr_arbiter_4 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (in_valid),
        .advance (advance_c),
        .gnt     (gnt_c)
    );

    // Ready is the grant, gated by load and suppressed during reset.
    assign in_ready  = (load_c && !rst) ? gnt_c : '0;
    assign gnt_idx_c = onehot_to_idx(gnt_c);

    // Select the winning channel's data.
    always_comb begin
        gnt_data_c = '0;
        unique case (gnt_idx_c)
            SEL_CH0: gnt_data_c = in0;
            SEL_CH1: gnt_data_c = in1;
            SEL_CH2: gnt_data_c = in2;
            SEL_CH3: gnt_data_c = in3;
            default: gnt_data_c = in0;
        endcase
    end

    // Output register; holds word and index under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= '0;
            s         <= SEL_CH0;
            out_valid <= 1'b0;
        end else if (load_c) begin
            if (|in_valid) begin
                out       <= gnt_data_c;
                s         <= gnt_idx_c;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
